// File: rtl/systolic_sched_pkg.sv
// Shared definitions for the systolic feed scheduler: one-hot state encoding
// and the step-counter width helper.
package systolic_sched_pkg;

    localparam int IDLE_B  = 0;
    localparam int FEED_B  = 1;
    localparam int DRAIN_B = 2;
    localparam int DONE_B  = 3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'(1 << IDLE_B),
        S_FEED  = 4'(1 << FEED_B),
        S_DRAIN = 4'(1 << DRAIN_B),
        S_DONE  = 4'(1 << DONE_B)
    } sched_state_t;

    // Step counter must cover k_len + LANES - 1 plus headroom for offset math.
    function automatic int t_width(input int k_w, input int lanes);
        return k_w + $clog2(lanes) + 1;
    endfunction

endpackage

// File: rtl/skew_window.sv
// Per-lane diagonal window: lane LANE_IDX is inside its window while
// LANE_IDX <= t < LANE_IDX + k_q.
module skew_window #(
    parameter int LANE_IDX = 0,
    parameter int K_W      = 8,
    parameter int TW       = 11
) (
    input  logic [TW-1:0]  t,
    input  logic [K_W-1:0] k_q,
    output logic           due
);

    localparam logic [TW-1:0] LO = TW'(LANE_IDX);

    logic [TW-1:0] w_off;

    // t < LO wraps to a value far above any k_q, so one compare covers both bounds.
    assign w_off = t - LO;
    assign due   = w_off < {{(TW-K_W){1'b0}}, k_q};

endmodule

// File: rtl/systolic_feed_scheduler.sv
// Skewed FIFO-read sequencer for the systolic array: staggers lane starts,
// freezes all lanes together on any empty due FIFO, then drains and signals done.
module systolic_feed_scheduler
    import systolic_sched_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int K_W       = 8,
    parameter int DRAIN_LEN = 8,
    parameter int STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [K_W-1:0]     k_len,
    input  logic [LANES-1:0]   fifo_empty,
    output logic [LANES-1:0]   lane_enb,
    output logic               busy,
    output logic               stall,
    output logic               done,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int TW = t_width(K_W, LANES);
    localparam int DW = $clog2(DRAIN_LEN + 1);
    localparam logic [TW-1:0] LAST_OFS = TW'(LANES - 2);

    sched_state_t       r_state, w_state_nxt;
    logic [TW-1:0]      r_t, w_t_nxt;
    logic [K_W-1:0]     r_k_q, w_k_nxt;
    logic [DW-1:0]      r_drain, w_drain_nxt;
    logic [STALL_W-1:0] r_stall_cnt, w_scnt_nxt;

    logic [LANES-1:0]   w_win;
    logic [LANES-1:0]   w_due;
    logic               w_feed;
    logic               w_freeze;
    logic [TW-1:0]      w_t_end;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            skew_window #(
                .LANE_IDX (gi),
                .K_W      (K_W),
                .TW       (TW)
            ) u_win (
                .t   (r_t),
                .k_q (r_k_q),
                .due (w_win[gi])
            );
        end
    endgenerate

    assign w_feed   = (r_state == S_FEED);
    assign w_due    = w_win & {LANES{w_feed}};
    assign w_freeze = |(w_due & fifo_empty);
    assign w_t_end  = {{(TW-K_W){1'b0}}, r_k_q} + LAST_OFS;

    assign lane_enb  = (w_freeze | abort) ? '0 : w_due;
    assign stall     = w_freeze;
    assign busy      = w_feed | (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_t         <= '0;
            r_k_q       <= '0;
            r_drain     <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_k_q       <= w_k_nxt;
            r_drain     <= w_drain_nxt;
            r_stall_cnt <= w_scnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_k_nxt     = r_k_q;
        w_drain_nxt = r_drain;
        w_scnt_nxt  = r_stall_cnt;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_k_nxt     = k_len;
                        w_t_nxt     = '0;
                        w_scnt_nxt  = '0;
                        w_state_nxt = (k_len == '0) ? S_DONE : S_FEED;
                    end
                end
                S_FEED: begin
                    if (w_freeze) begin
                        if (r_stall_cnt != '1)
                            w_scnt_nxt = r_stall_cnt + STALL_W'(1);
                    end else begin
                        w_t_nxt = r_t + TW'(1);
                        if (r_t == w_t_end) begin
                            w_state_nxt = S_DRAIN;
                            w_drain_nxt = DW'(DRAIN_LEN - 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0)
                        w_state_nxt = S_DONE;
                    else
                        w_drain_nxt = r_drain - DW'(1);
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Directed bench for systolic_feed_scheduler: skew sequence, freeze, abort,
// zero-length jobs and asynchronous reset, each against hand-computed values.
module tb_systolic_feed_scheduler;

    localparam int LANES     = 4;
    localparam int K_W       = 8;
    localparam int DRAIN_LEN = 8;
    localparam int STALL_W   = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [K_W-1:0]     k_len = '0;
    logic [LANES-1:0]   fifo_empty = '0;
    logic [LANES-1:0]   lane_enb;
    logic               busy;
    logic               stall;
    logic               done;
    logic [STALL_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    systolic_feed_scheduler #(
        .LANES     (LANES),
        .K_W       (K_W),
        .DRAIN_LEN (DRAIN_LEN),
        .STALL_W   (STALL_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .k_len      (k_len),
        .fifo_empty (fifo_empty),
        .lane_enb   (lane_enb),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic go(input logic [K_W-1:0] k);
        start = 1'b1;
        k_len = k;
        cyc();
        start = 1'b0;
    endtask

    // One FEED cycle: check enables/stall/busy, then advance.
    task automatic feed(input string tag, input logic [3:0] enb, input logic stl);
        #1;
        chk({tag, "_enb"}, 32'(lane_enb), 32'(enb));
        chk({tag, "_stall"}, 32'(stall), 32'(stl));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cyc();
    endtask

    task automatic drain_done(input string tag);
        for (int i = 0; i < DRAIN_LEN; i++) begin
            #1;
            chk({tag, "_drain_busy"}, 32'(busy), 32'd1);
            chk({tag, "_drain_enb"}, 32'(lane_enb), 32'd0);
            chk({tag, "_drain_done"}, 32'(done), 32'd0);
            cyc();
        end
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd0);
        cyc();
        #1;
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_enb", 32'(lane_enb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_scnt", 32'(stall_cnt), 32'd0);
        cyc();
        rstn = 1'b1;
        cyc();

        // 1: k=3, clean run; a start during FEED must be ignored
        go(8'd3);
        feed("t1_0", 4'b0001, 1'b0);
        start = 1'b1; k_len = 8'd7;
        feed("t1_1", 4'b0011, 1'b0);
        start = 1'b0;
        feed("t1_2", 4'b0111, 1'b0);
        feed("t1_3", 4'b1110, 1'b0);
        feed("t1_4", 4'b1100, 1'b0);
        feed("t1_5", 4'b1000, 1'b0);
        drain_done("t1");
        chk("t1_scnt", 32'(stall_cnt), 32'd0);

        // 2: lane 2 empty for two cycles at t=2
        go(8'd3);
        feed("t2_0", 4'b0001, 1'b0);
        feed("t2_1", 4'b0011, 1'b0);
        fifo_empty = 4'b0100;
        feed("t2_f0", 4'b0000, 1'b1);
        feed("t2_f1", 4'b0000, 1'b1);
        fifo_empty = 4'b0000;
        feed("t2_2", 4'b0111, 1'b0);
        feed("t2_3", 4'b1110, 1'b0);
        feed("t2_4", 4'b1100, 1'b0);
        feed("t2_5", 4'b1000, 1'b0);
        #1;
        chk("t2_scnt", 32'(stall_cnt), 32'd2);
        drain_done("t2");
        chk("t2_scnt_after", 32'(stall_cnt), 32'd2);

        // 3: lane 3 empty before its window opens has no effect
        go(8'd3);
        fifo_empty = 4'b1000;
        feed("t3_0", 4'b0001, 1'b0);
        feed("t3_1", 4'b0011, 1'b0);
        feed("t3_2", 4'b0111, 1'b0);
        fifo_empty = 4'b0000;
        feed("t3_3", 4'b1110, 1'b0);
        feed("t3_4", 4'b1100, 1'b0);
        feed("t3_5", 4'b1000, 1'b0);
        drain_done("t3");
        chk("t3_scnt", 32'(stall_cnt), 32'd0);

        // 4: zero-length job goes straight to DONE
        #1;
        chk("t4_pre_busy", 32'(busy), 32'd0);
        go(8'd0);
        #1;
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_enb", 32'(lane_enb), 32'd0);
        cyc();
        #1;
        chk("t4_done_clr", 32'(done), 32'd0);
        chk("t4_busy2", 32'(busy), 32'd0);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; k_len = 8'd3;
        cyc();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_done", 32'(done), 32'd0);
        cyc();
        #1;
        chk("sa_busy2", 32'(busy), 32'd0);

        // 5: one stall, then abort at t=3; stall_cnt holds; restart with k=2
        go(8'd3);
        feed("t5_0", 4'b0001, 1'b0);
        fifo_empty = 4'b0001;
        feed("t5_f", 4'b0000, 1'b1);
        fifo_empty = 4'b0000;
        feed("t5_1", 4'b0011, 1'b0);
        feed("t5_2", 4'b0111, 1'b0);
        abort = 1'b1;
        #1;
        chk("t5_abort_enb", 32'(lane_enb), 32'd0);
        cyc();
        abort = 1'b0;
        #1;
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_enb", 32'(lane_enb), 32'd0);
        chk("t5_idle_done", 32'(done), 32'd0);
        chk("t5_scnt_hold", 32'(stall_cnt), 32'd1);
        cyc();
        #1;
        chk("t5_idle_done2", 32'(done), 32'd0);
        go(8'd2);
        #1;
        chk("t5_scnt_clr", 32'(stall_cnt), 32'd0);
        feed("t5b_0", 4'b0001, 1'b0);
        feed("t5b_1", 4'b0011, 1'b0);
        feed("t5b_2", 4'b0110, 1'b0);
        feed("t5b_3", 4'b1100, 1'b0);
        feed("t5b_4", 4'b1000, 1'b0);
        drain_done("t5b");

        // 6: asynchronous reset mid-DRAIN, then a k=1 job
        go(8'd3);
        feed("t6_0", 4'b0001, 1'b0);
        fifo_empty = 4'b0001;
        feed("t6_f", 4'b0000, 1'b1);
        fifo_empty = 4'b0000;
        feed("t6_1", 4'b0011, 1'b0);
        feed("t6_2", 4'b0111, 1'b0);
        feed("t6_3", 4'b1110, 1'b0);
        feed("t6_4", 4'b1100, 1'b0);
        feed("t6_5", 4'b1000, 1'b0);
        cyc();
        cyc();
        #1;
        chk("t6_drain_busy", 32'(busy), 32'd1);
        chk("t6_drain_scnt", 32'(stall_cnt), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_enb", 32'(lane_enb), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_stall", 32'(stall), 32'd0);
        chk("t6_rst_scnt", 32'(stall_cnt), 32'd0);
        cyc();
        rstn = 1'b1;
        cyc();
        go(8'd1);
        feed("t6b_0", 4'b0001, 1'b0);
        feed("t6b_1", 4'b0010, 1'b0);
        feed("t6b_2", 4'b0100, 1'b0);
        feed("t6b_3", 4'b1000, 1'b0);
        drain_done("t6b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feed_scheduler.md
Name: systolic_feed_scheduler

Overview:
Sequences the per-row input FIFO consumers of the systolic array so that operand rows enter with the diagonal skew the array requires. Lane i starts reading i cycles after lane 0, and every lane reads exactly k_len words. If any FIFO that is due to be read is empty, all lanes freeze together, so the skew is never broken. After the last word is read, the block waits a fixed drain time for the array pipeline to flush, then pulses done.

Parameters:
LANES, 4, number of FIFO consumer lanes (array rows); must be ≥2.
K_W, 8, width of the k_len operand; maximum per-lane length is 2^K_W-1.
DRAIN_LEN, 8, cycles spent in DRAIN after the last read; must be ≥1.
STALL_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse starting a job; ignored unless in IDLE.
abort  input  1  synchronous cancel; highest priority after reset.
k_len  input  K_W  words per lane; sampled only on an accepted start.
fifo_empty  input  LANES  empty flag from each lane's FIFO consumer.
lane_enb  output  LANES  read-enable to each lane's FIFO consumer.
busy  output  1  high in FEED or DRAIN.
stall  output  1  high when FEED is frozen by an empty due lane.
done  output  1  one-cycle completion pulse.
stall_cnt  output  STALL_W  frozen FEED cycles in the current or last job; saturates.

Behaviour:
- States (one-hot): IDLE, FEED, DRAIN, DONE.
- Reset (rstn=0, asynchronous):
  - state=IDLE, t=0, drain counter=0, k_q=0, stall_cnt=0.
  - Outputs: lane_enb=0, busy=0, stall=0, done=0.
- Registers:
  - Step counter t, width K_W+$clog2(LANES)+1.
  - Latched length k_q.
  - Drain counter, width $clog2(DRAIN_LEN+1).
- Lane window: lane i is due when state==FEED and i ≤ t ≤ i+k_q-1.
- freeze = OR over i of (due_i & fifo_empty[i]).
- Combinational outputs (same-cycle, no register stage):
  - lane_enb[i] = due_i & ~freeze.
  - stall = freeze.
  - A FIFO read therefore happens in the cycle lane_enb is asserted.
- IDLE:
  - On start: latch k_q=k_len, clear t=0, clear stall_cnt=0.
  - If k_len==0, go to DONE; otherwise go to FEED.
  - busy=0.
- FEED:
  - If ~freeze: t increments.
  - If ~freeze and t == k_q+LANES-2: go to DRAIN and load the drain counter with DRAIN_LEN-1.
  - If freeze: t holds, stall_cnt increments (saturating at all-ones), no lane enabled.
  - Total FEED cycles = k_q+LANES-1 + number of frozen cycles.
- DRAIN:
  - Counter decrements each cycle.
  - When it is 0, go to DONE.
  - fifo_empty is ignored.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy = FEED | DRAIN.
- start while busy or in DONE: ignored; k_q unchanged.
- abort in any state:
  - Next state IDLE, t=0; no done pulse.
  - lane_enb is forced 0 in the abort cycle.
  - stall_cnt holds its value.
- start and abort in the same IDLE cycle: abort wins and the start is dropped.
- Reset asserted mid-job: immediate return to the reset values above.
- Partial freeze: even if only one due lane is empty, no lane reads in that cycle. Freeze is all-or-nothing, which preserves the diagonal alignment.
- stall_cnt remains readable after done until the next accepted start.

Decomposition:
- Package systolic_sched_pkg holds:
  - State bit indices IDLE_B, FEED_B, DRAIN_B, DONE_B.
  - sched_state_t one-hot enum built from those indices.
  - Localparam helper for the t width.
- One sub-module, skew_window: pure combinational per-lane due comparator.
  - Parameter LANE_IDX.
  - Inputs t and k_q; output due.
  - Instantiated LANES times in a generate loop.
- The FSM, counters and freeze OR stay in the top module.

Test Plan:
1. LANES=4, DRAIN_LEN=8, k_len=3, all FIFOs non-empty. Start at cycle 0 (IDLE→FEED).
   - FEED lasts 6 cycles (t=0..5). lane_enb sequence: 0001, 0011, 0111, 1110, 1100, 1000.
   - Then 8 DRAIN cycles, then done high for one cycle. stall_cnt=0.
2. Same setup with fifo_empty[2]=1 held for 2 cycles while t=2.
   - lane_enb=0000 and stall=1 for both cycles; t holds at 2.
   - Sequence then resumes unchanged. stall_cnt=2, FEED length 8.
3. fifo_empty[3]=1 throughout t=0..2 (lane 3 not yet due).
   - No freeze and stall stays 0; lane 3 has no effect before its window opens.
4. k_len=0 start.
   - Next cycle done=1, busy never asserts, lane_enb stays 0.
5. Abort at t=3.
   - Next cycle IDLE, lane_enb=0, no done pulse.
   - A second start with k_len=2 then completes normally: FEED 5 cycles.
6. rstn dropped asynchronously mid-DRAIN.
   - All outputs reach their reset values without a clock edge.
   - A start after reset release with k_len=1 gives FEED 4 cycles, lane_enb one-hot 0001→1000.
